// File: rtl/div_ratio_detect.sv
// div_ratio_detect -- measures the period, high time and low time of a divided
// clock (sig_in) in clk_in cycles, and flags lock after LOCK_N identical periods.
// Optional macro DIV_DETECT_SYNC_EN: sig_in passes a two-flop synchronizer
// first, adding two cycles of latency to every valid/err pulse.
module div_ratio_detect #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] ratio,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             valid,
    output logic             locked,
    output logic             err
);

    // Match counter only has to reach LOCK_N, which is at most 15.
    localparam int                 MATCH_W   = 4;
    localparam logic [MATCH_W-1:0] LOCK_M    = MATCH_W'(LOCK_N);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic [CNT_W-1:0]   hi_q, hi_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [CNT_W-1:0]   ratio_q, ratio_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic [CNT_W-1:0]   low_q, low_d;
    logic               valid_q, valid_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic               sig_pre;
    logic               sig_s_q, sig_d_q;
    logic               rise;

`ifdef DIV_DETECT_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for an sig_in that is asynchronous to clk_in.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its source, independent of statement order.
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sig_in};
        end
    end

    assign sig_pre = sync_q[1];
`else
    assign sig_pre = sig_in;
`endif

    // Sample sig_in and keep one cycle of history for edge detection.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sig_s_q <= 1'b0;
            sig_d_q <= 1'b0;
        end else begin
            sig_s_q <= sig_pre;
            sig_d_q <= sig_s_q;
        end
    end

    assign rise = sig_s_q & ~sig_d_q;

    // Next-state logic: FSM, period/high counters, result capture and lock tracking.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_d  = state_q;
        per_d    = per_q;
        hi_d     = hi_q;
        match_d  = match_q;
        locked_d = locked_q;
        ratio_d  = ratio_q;
        high_d   = high_q;
        low_d    = low_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (!en) begin
            state_d  = IDLE;
            per_d    = '0;
            hi_d     = '0;
            match_d  = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                end
                ARM: begin
                    // The rise cycle itself is the first (high) cycle of the period.
                    if (rise) begin
                        per_d   = CNT_ONE;
                        hi_d    = CNT_ONE;
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        ratio_d = per_q;
                        high_d  = hi_q;
                        low_d   = per_q - hi_q;
                        valid_d = 1'b1;
                        per_d   = CNT_ONE;
                        hi_d    = CNT_ONE;
                        // match_q == 0 means there is no previous period to compare with.
                        if ((match_q == '0) || (per_q != ratio_q)) begin
                            match_d = MATCH_ONE;
                        end else if (match_q < LOCK_M) begin
                            match_d = match_q + MATCH_ONE;
                        end
                        locked_d = (match_d >= LOCK_M);
                    end else if (per_q == CNT_MAX) begin
                        // Period too long to count: drop lock and wait for a fresh edge.
                        err_d    = 1'b1;
                        match_d  = '0;
                        locked_d = 1'b0;
                        per_d    = '0;
                        hi_d     = '0;
                        state_d  = ARM;
                    end else begin
                        per_d = per_q + CNT_ONE;
                        if (sig_s_q) begin
                            hi_d = hi_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q  <= IDLE;
            per_q    <= '0;
            hi_q     <= '0;
            match_q  <= '0;
            ratio_q  <= '0;
            high_q   <= '0;
            low_q    <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            match_q  <= match_d;
            ratio_q  <= ratio_d;
            high_q   <= high_d;
            low_q    <= low_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign ratio    = ratio_q;
    assign high_cnt = high_q;
    assign low_cnt  = low_q;
    assign valid    = valid_q;
    assign locked   = locked_q;
    assign err      = err_q;

endmodule

// File: tb/tb_div_ratio_detect.sv
// Directed testbench for div_ratio_detect (CNT_W=8, LOCK_N=4).
// A negedge monitor logs valid/err events; each test compares the log against
// hand-computed values and against the recorded cycles of the driven rising edges.
module tb_div_ratio_detect;

`ifdef DIV_DETECT_SYNC_EN
    localparam int DLY = 4;
`else
    localparam int DLY = 2;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] r;
        logic [7:0] h;
        logic [7:0] l;
        logic       lk;
    } ev_t;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       en     = 1'b0;
    logic       sig_in = 1'b0;
    logic [7:0] ratio, high_cnt, low_cnt;
    logic       valid, locked, err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic both_seen = 1'b0;
    ev_t  vq[$];
    int   eq[$];
    int   rq[$];

    div_ratio_detect #(.CNT_W(8), .LOCK_N(4)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .sig_in   (sig_in),
        .ratio    (ratio),
        .high_cnt (high_cnt),
        .low_cnt  (low_cnt),
        .valid    (valid),
        .locked   (locked),
        .err      (err)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (valid === 1'b1) vq.push_back('{cyc, ratio, high_cnt, low_cnt, locked});
        if (err === 1'b1) eq.push_back(cyc);
        if (valid === 1'b1 && err === 1'b1) both_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic set_sig(input logic v);
        if (v && !sig_in) rq.push_back(cyc);
        sig_in = v;
    endtask

    task automatic drive_div(input int n, input int nper);
        repeat (nper) begin
            set_sig(1'b1);
            tick(n / 2);
            set_sig(1'b0);
            tick(n / 2);
        end
    endtask

    task automatic clear_logs();
        vq.delete();
        eq.delete();
        rq.delete();
    endtask

    task automatic start_meas();
        en = 1'b1;
        set_sig(1'b0);
        tick(4);
        clear_logs();
    endtask

    task automatic stop_meas();
        en = 1'b0;
        set_sig(1'b0);
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        set_sig(1'b0);
        tick(3);
        n_cmp++;
        if ({ratio, high_cnt, low_cnt, valid, locked, err} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got r=%h h=%h l=%h v=%b lk=%b e=%b want all 0",
                     ratio, high_cnt, low_cnt, valid, locked, err);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_div2();
        logic [24:0] got, exp;
        start_meas();
        drive_div(2, 6);
        set_sig(1'b0);
        tick(DLY + 2);
        n_cmp++;
        if (vq.size() !== 5) begin
            n_bad++;
            $display("FAIL div2_count: got %0d valids want 5", vq.size());
        end
        for (int k = 0; k < 5 && k < vq.size(); k++) begin
            got = {vq[k].r, vq[k].h, vq[k].l, vq[k].lk};
            exp = {8'd2, 8'd1, 8'd1, (k >= 3) ? 1'b1 : 1'b0};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL div2_value[%0d]: got %h want %h", k, got, exp);
            end
            n_cmp++;
            if (vq[k].cyc !== rq[k + 1] + DLY) begin
                n_bad++;
                $display("FAIL div2_latency[%0d]: got cycle %0d want %0d", k, vq[k].cyc, rq[k + 1] + DLY);
            end
        end
        // Disable while sig_in keeps toggling: lock drops, no valid, results hold.
        clear_logs();
        en = 1'b0;
        tick(1);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL en_off_locked: got %b want 0", locked);
        end
        drive_div(2, 4);
        tick(DLY + 2);
        n_cmp++;
        if (vq.size() !== 0 || eq.size() !== 0) begin
            n_bad++;
            $display("FAIL en_off_pulses: got %0d valids %0d errs want 0 0", vq.size(), eq.size());
        end
        n_cmp++;
        if ({ratio, high_cnt, low_cnt} !== {8'd2, 8'd1, 8'd1}) begin
            n_bad++;
            $display("FAIL en_off_hold: got r=%0d h=%0d l=%0d want 2 1 1", ratio, high_cnt, low_cnt);
        end
        stop_meas();
    endtask

    task automatic test_div8();
        logic [24:0] got, exp;
        start_meas();
        drive_div(8, 6);
        set_sig(1'b0);
        tick(DLY + 2);
        n_cmp++;
        if (vq.size() !== 5) begin
            n_bad++;
            $display("FAIL div8_count: got %0d valids want 5", vq.size());
        end
        for (int k = 0; k < 5 && k < vq.size(); k++) begin
            got = {vq[k].r, vq[k].h, vq[k].l, vq[k].lk};
            exp = {8'd8, 8'd4, 8'd4, (k >= 3) ? 1'b1 : 1'b0};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL div8_value[%0d]: got %h want %h", k, got, exp);
            end
            n_cmp++;
            if (vq[k].cyc !== rq[k + 1] + DLY) begin
                n_bad++;
                $display("FAIL div8_latency[%0d]: got cycle %0d want %0d", k, vq[k].cyc, rq[k + 1] + DLY);
            end
        end
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL div8_lock_held: got %b want 1", locked);
        end
        stop_meas();
    endtask

    task automatic test_switch();
        logic [24:0] got, exp;
        logic [7:0]  er;
        logic        el;
        start_meas();
        drive_div(4, 6);
        drive_div(8, 5);
        set_sig(1'b0);
        tick(DLY + 2);
        n_cmp++;
        if (vq.size() !== 10) begin
            n_bad++;
            $display("FAIL switch_count: got %0d valids want 10", vq.size());
        end
        for (int k = 0; k < 10 && k < vq.size(); k++) begin
            er  = (k < 6) ? 8'd4 : 8'd8;
            el  = ((k >= 3 && k <= 5) || k == 9) ? 1'b1 : 1'b0;
            got = {vq[k].r, vq[k].h, vq[k].l, vq[k].lk};
            exp = {er, er >> 1, er >> 1, el};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL switch_value[%0d]: got %h want %h", k, got, exp);
            end
            n_cmp++;
            if (vq[k].cyc !== rq[k + 1] + DLY) begin
                n_bad++;
                $display("FAIL switch_latency[%0d]: got cycle %0d want %0d", k, vq[k].cyc, rq[k + 1] + DLY);
            end
        end
        stop_meas();
    endtask

    task automatic test_overflow();
        int last_rise;
        start_meas();
        drive_div(4, 6);
        set_sig(1'b1);
        last_rise = cyc;
        tick(2);
        set_sig(1'b0);
        for (int i = 0; i < 400 && eq.size() == 0; i++) tick(1);
        tick(3);
        n_cmp++;
        if (eq.size() !== 1) begin
            n_bad++;
            $display("FAIL ovf_err_count: got %0d err pulses want 1", eq.size());
        end
        if (eq.size() > 0) begin
            n_cmp++;
            if (eq[0] !== last_rise + DLY + 255) begin
                n_bad++;
                $display("FAIL ovf_err_time: got cycle %0d want %0d", eq[0], last_rise + DLY + 255);
            end
        end
        n_cmp++;
        if (vq.size() !== 6) begin
            n_bad++;
            $display("FAIL ovf_valid_count: got %0d valids want 6", vq.size());
        end
        n_cmp++;
        if ({ratio, high_cnt, low_cnt, locked} !== {8'd4, 8'd2, 8'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL ovf_hold: got r=%0d h=%0d l=%0d lk=%b want 4 2 2 0",
                     ratio, high_cnt, low_cnt, locked);
        end
        // Back in ARM: one arming rise plus one full period gives a single valid.
        clear_logs();
        drive_div(4, 2);
        set_sig(1'b0);
        tick(DLY + 2);
        n_cmp++;
        if (vq.size() !== 1) begin
            n_bad++;
            $display("FAIL ovf_rearm_count: got %0d valids want 1", vq.size());
        end else begin
            n_cmp++;
            if ({vq[0].r, vq[0].h, vq[0].l, vq[0].lk} !== {8'd4, 8'd2, 8'd2, 1'b0} ||
                vq[0].cyc !== rq[1] + DLY) begin
                n_bad++;
                $display("FAIL ovf_rearm_value: got r=%0d h=%0d l=%0d lk=%b at %0d want 4 2 2 0 at %0d",
                         vq[0].r, vq[0].h, vq[0].l, vq[0].lk, vq[0].cyc, rq[1] + DLY);
            end
        end
        stop_meas();
    endtask

    task automatic test_rst_mid();
        start_meas();
        drive_div(4, 3);
        set_sig(1'b1);
        tick(2);
        rst = 1'b1;
        set_sig(1'b0);
        tick(1);
        n_cmp++;
        if ({ratio, high_cnt, low_cnt, valid, locked, err} !== 27'd0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got r=%h h=%h l=%h v=%b lk=%b e=%b want all 0",
                     ratio, high_cnt, low_cnt, valid, locked, err);
        end
        rst = 1'b0;
        clear_logs();
        tick(2);
        drive_div(4, 3);
        set_sig(1'b0);
        tick(DLY + 2);
        n_cmp++;
        if (vq.size() !== 2) begin
            n_bad++;
            $display("FAIL rst_mid_count: got %0d valids want 2", vq.size());
        end
        for (int k = 0; k < 2 && k < vq.size(); k++) begin
            n_cmp++;
            if ({vq[k].r, vq[k].h, vq[k].l, vq[k].lk} !== {8'd4, 8'd2, 8'd2, 1'b0} ||
                vq[k].cyc !== rq[k + 1] + DLY) begin
                n_bad++;
                $display("FAIL rst_mid_value[%0d]: got r=%0d h=%0d l=%0d lk=%b at %0d want 4 2 2 0 at %0d",
                         k, vq[k].r, vq[k].h, vq[k].l, vq[k].lk, vq[k].cyc, rq[k + 1] + DLY);
            end
        end
        stop_meas();
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (both_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL valid_err_exclusive: got overlap=%b want 0", both_seen);
        end
    endtask

    initial begin
        test_reset();
        test_div2();
        test_div8();
        test_switch();
        test_overflow();
        test_rst_mid();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_ratio_detect.md
DIV_RATIO_DETECT -- requirements
Module: div_ratio_detect

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of period/high/low counters and outputs.
REQ-002 SHALL have parameter LOCK_N, default 4, consecutive identical periods required for lock (range 2..15).
REQ-003 SHALL have port clk_in  input  1  sole clock; all logic on posedge clk_in.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  measurement enable.
REQ-006 SHALL have port sig_in  input  1  divided clock under test (e.g. a divide-by-2/4/8 output), sampled by clk_in.
REQ-007 SHALL have port ratio  output  CNT_W  last measured period in clk_in cycles.
REQ-008 SHALL have port high_cnt  output  CNT_W  clk_in cycles sig_in was high in last period.
REQ-009 SHALL have port low_cnt  output  CNT_W  clk_in cycles sig_in was low in last period.
REQ-010 SHALL have port valid  output  1  one-cycle pulse when ratio/high_cnt/low_cnt update.
REQ-011 SHALL have port locked  output  1  LOCK_N consecutive identical periods seen.
REQ-012 SHALL have port err  output  1  one-cycle pulse on period-counter overflow.

Function
REQ-013 SHALL derive sig_s (sampled sig_in) and sig_d (sig_s delayed one cycle); rise = sig_s & ~sig_d.
REQ-014 SHALL implement FSM states IDLE, ARM, MEAS; encoding is implementer's choice.
REQ-015 IDLE: when en=1 go to ARM; stay otherwise.
REQ-016 ARM: on rise, load period counter = 1, high counter = 1, go to MEAS.
REQ-017 MEAS: each cycle without rise, period counter +1 and high counter +1 if sig_s=1.
REQ-018 MEAS on rise: register ratio = period counter, high_cnt = high counter, low_cnt = period counter - high counter; assert valid next cycle; reload counters to 1; stay in MEAS.
REQ-019 Measurement SHALL be exact: divide-by-N input gives ratio = N, high_cnt = N/2, low_cnt = N/2 for even N.
REQ-020 Overflow: if period counter = 2^CNT_W-1 in MEAS with no rise, pulse err next cycle, clear locked and match count, go to ARM; ratio/high_cnt/low_cnt hold.
REQ-021 Lock: keep match count; first valid period sets it to 1; equal ratio to previous increments it (saturating at LOCK_N); differing ratio sets it to 1 and clears locked.
REQ-022 locked SHALL rise in the same cycle as the valid pulse of the LOCK_N-th consecutive identical period.
REQ-023 en=0 in any state: go IDLE next cycle, clear locked, match count and counters; ratio/high_cnt/low_cnt hold; no valid or err.
REQ-024 rise and overflow in same cycle: rise wins (valid, no err).
REQ-025 valid and err SHALL never assert in the same cycle.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, counters 0, match count 0, sig_s/sig_d 0, ratio/high_cnt/low_cnt 0, valid/locked/err 0.
REQ-027 rst mid-measurement SHALL discard the partial period; next valid needs a fresh ARM rise plus a full period.

Configuration
REQ-028 Macro DIV_DETECT_SYNC_EN defined: sig_in passes a two-flop synchronizer before sig_s, adding 2 clk_in cycles latency to every valid/err; measured values unchanged.
REQ-029 Macro undefined: sig_in SHALL be registered once directly into sig_s (sig_in treated as synchronous to clk_in).

Verification
REQ-030 Divide-by-2 sig_in, en=1 after reset -> valid every 2 cycles, ratio=2, high_cnt=1, low_cnt=1; locked on 4th valid.
REQ-031 Divide-by-8 sig_in -> ratio=8, high_cnt=4, low_cnt=4; locked on 4th valid, stays set.
REQ-032 Lock at divide-by-4 then switch to divide-by-8 -> first ratio=8 valid clears locked; locked again 3 valids later.
REQ-033 sig_in stuck 0 after one rise, CNT_W=8 -> err pulse 255 cycles after the rise, locked=0, state ARM, ratio held.
REQ-034 rst=1 for one cycle mid-period with divide-by-4 -> all outputs 0 next cycle; first valid only after ARM rise plus 4 cycles, ratio=4.
REQ-035 Repeat REQ-030 with DIV_DETECT_SYNC_EN defined -> identical values, every valid delayed exactly 2 cycles.
